connect_win_scanner: RTL and testbench

- Parametrised, sequential successor to the combinational diagonal win checker.
- After each piece drop, the block walks the stored board outward from the new piece in all four line directions: horizontal, vertical, rising diagonal and falling diagonal.
- It counts contiguous cells belonging to the current player and reports a win when a run reaches WIN_LEN.
- It sits between the drop controller (start/done handshake) and the board memory (1-cycle-latency read port).

---
 rtl/connect_win_scanner_if.sv | 30 +++
 rtl/connect_win_scanner.sv | 177 +++++++++++++++++
 tb/tb_connect_win_scanner.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/connect_win_scanner_if.sv
// Handshake and board-read bundle between the drop controller/board memory and the scanner.
interface connect_win_scanner_if #(
    parameter int unsigned COL_W = 3,
    parameter int unsigned ROW_W = 3
);
    logic             start;
    logic             player;
    logic [COL_W-1:0] location;
    logic [ROW_W-1:0] height;
    logic             early_win;
    logic [COL_W-1:0] rd_col;
    logic [ROW_W-1:0] rd_row;
    logic             rd_en;
    logic [1:0]       rd_cell;
    logic             busy;
    logic             done;
    logic             won_game;
    logic [1:0]       win_dir;
    logic             err;

    modport master (
        output start, player, location, height, early_win, rd_cell,
        input  rd_col, rd_row, rd_en, busy, done, won_game, win_dir, err
    );

    modport slave (
        input  start, player, location, height, early_win, rd_cell,
        output rd_col, rd_row, rd_en, busy, done, won_game, win_dir, err
    );
endinterface

// File: rtl/connect_win_scanner.sv
// Sequential win scanner: walks the board outward from the last drop in four line directions,
// counting contiguous cells of the moving player until a run of WIN_LEN is found.
module connect_win_scanner #(
    parameter int unsigned COLS    = 7,
    parameter int unsigned ROWS    = 6,
    parameter int unsigned WIN_LEN = 4,
    parameter int unsigned COL_W   = 3,
    parameter int unsigned ROW_W   = 3
) (
    input logic                  clk,
    input logic                  reset,
    connect_win_scanner_if.slave bus
);

    localparam int unsigned CW     = COL_W + 2;
    localparam int unsigned RW     = ROW_W + 2;
    localparam logic [3:0]  WinLen = 4'(WIN_LEN);
    localparam logic [3:0]  KMax   = 4'(WIN_LEN - 1);

    typedef enum logic [1:0] {StIdle, StProbe, StCheck, StFinish} state_e;

    state_e           state_q, state_d;
    logic             player_q, player_d;
    logic [COL_W-1:0] loc_q, loc_d;
    logic [ROW_W-1:0] hgt_q, hgt_d;
    logic [1:0]       dir_q, dir_d;
    logic             neg_q, neg_d;
    logic [3:0]       k_q, k_d;
    logic [3:0]       count_q, count_d;
    logic             won_q, won_d;
    logic             err_q, err_d;
    logic [1:0]       win_dir_q, win_dir_d;

    logic signed [CW-1:0] tcol;
    logic signed [RW-1:0] trow;
    logic                 in_bounds;
    logic                 match;
    logic                 advance;
    logic                 start_oor;

    // Target = origin + s*k*(dx,dy); extra sign/guard bits keep off-board targets from wrapping.
    always_comb begin
        tcol = CW'(loc_q);
        trow = RW'(hgt_q);
        if (dir_q != 2'd1) begin
            tcol = neg_q ? tcol - CW'(k_q) : tcol + CW'(k_q);
        end
        case (dir_q)
            2'd1, 2'd2: trow = neg_q ? trow - RW'(k_q) : trow + RW'(k_q);
            2'd3:       trow = neg_q ? trow + RW'(k_q) : trow - RW'(k_q);
            default:    ;
        endcase
    end

    assign in_bounds = !tcol[CW-1] && (tcol[CW-2:0] < (CW-1)'(COLS)) &&
                       !trow[RW-1] && (trow[RW-2:0] < (RW-1)'(ROWS));
    assign match     = (bus.rd_cell == {player_q, ~player_q});
    assign start_oor = ({1'b0, bus.location} >= (COL_W+1)'(COLS)) ||
                       ({1'b0, bus.height} >= (ROW_W+1)'(ROWS));

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        loc_d     = loc_q;
        hgt_d     = hgt_q;
        dir_d     = dir_q;
        neg_d     = neg_q;
        k_d       = k_q;
        count_d   = count_q;
        won_d     = won_q;
        err_d     = err_q;
        win_dir_d = win_dir_q;
        advance   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    player_d  = bus.player;
                    loc_d     = bus.location;
                    hgt_d     = bus.height;
                    won_d     = 1'b0;
                    err_d     = 1'b0;
                    win_dir_d = 2'd0;
                    if (bus.early_win) begin
                        won_d   = 1'b1;
                        state_d = StFinish;
                    end else if (start_oor) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else begin
                        dir_d   = 2'd0;
                        neg_d   = 1'b0;
                        k_d     = 4'd1;
                        count_d = 4'd1;
                        state_d = StProbe;
                    end
                end
            end
            StProbe: begin
                if (in_bounds) state_d = StCheck;
                else           advance = 1'b1;
            end
            StCheck: begin
                if (match) begin
                    count_d = count_q + 4'd1;
                    if (count_q + 4'd1 == WinLen) begin
                        won_d     = 1'b1;
                        win_dir_d = dir_q;
                        state_d   = StFinish;
                    end else if (k_q == KMax) begin
                        advance = 1'b1;
                    end else begin
                        k_d     = k_q + 4'd1;
                        state_d = StProbe;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Current side exhausted: flip to the minus side, or move on to the next direction.
        if (advance) begin
            k_d     = 4'd1;
            state_d = StProbe;
            if (!neg_q) begin
                neg_d = 1'b1;
            end else if (dir_q == 2'd3) begin
                state_d = StFinish;
            end else begin
                dir_d   = dir_q + 2'd1;
                neg_d   = 1'b0;
                count_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            player_q  <= 1'b0;
            loc_q     <= '0;
            hgt_q     <= '0;
            dir_q     <= 2'd0;
            neg_q     <= 1'b0;
            k_q       <= 4'd0;
            count_q   <= 4'd0;
            won_q     <= 1'b0;
            err_q     <= 1'b0;
            win_dir_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            loc_q     <= loc_d;
            hgt_q     <= hgt_d;
            dir_q     <= dir_d;
            neg_q     <= neg_d;
            k_q       <= k_d;
            count_q   <= count_d;
            won_q     <= won_d;
            err_q     <= err_d;
            win_dir_q <= win_dir_d;
        end
    end

    assign bus.rd_en    = (state_q == StProbe) && in_bounds;
    assign bus.rd_col   = bus.rd_en ? tcol[COL_W-1:0] : '0;
    assign bus.rd_row   = bus.rd_en ? trow[ROW_W-1:0] : '0;
    assign bus.busy     = (state_q == StProbe) || (state_q == StCheck);
    assign bus.done     = (state_q == StFinish);
    assign bus.won_game = won_q;
    assign bus.win_dir  = win_dir_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_connect_win_scanner.sv
// Scoreboard bench: two scanners (WIN_LEN 4 and 3) share one board model and stimulus;
// expected results come from a direct line-counting reference model.
module tb_connect_win_scanner;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       player = 1'b0;
    logic       early_win = 1'b0;
    logic [2:0] location = '0;
    logic [2:0] height = '0;
    logic [1:0] cell4 = 2'b00;
    logic [1:0] cell3 = 2'b00;
    logic [1:0] board [COLS][ROWS];

    int         checks = 0;
    int         errors = 0;
    int         rd_cnt4 = 0;
    int         rd_cnt3 = 0;
    logic [3:0] q4[$];
    logic [3:0] q3[$];

    always #5 clk = ~clk;

    connect_win_scanner_if #(.COL_W(3), .ROW_W(3)) if4 ();
    connect_win_scanner_if #(.COL_W(3), .ROW_W(3)) if3 ();

    assign if4.start = start;      assign if3.start = start;
    assign if4.player = player;    assign if3.player = player;
    assign if4.location = location; assign if3.location = location;
    assign if4.height = height;    assign if3.height = height;
    assign if4.early_win = early_win; assign if3.early_win = early_win;
    assign if4.rd_cell = cell4;    assign if3.rd_cell = cell3;

    connect_win_scanner #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(4), .COL_W(3), .ROW_W(3)) dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave)
    );
    connect_win_scanner #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(3), .COL_W(3), .ROW_W(3)) dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave)
    );

    // Board memory with one-cycle read latency per scanner
    always @(posedge clk) begin
        if (if4.rd_en)
            cell4 <= (int'(if4.rd_col) < COLS && int'(if4.rd_row) < ROWS) ?
                     board[if4.rd_col][if4.rd_row] : 2'b11;
        if (if3.rd_en)
            cell3 <= (int'(if3.rd_col) < COLS && int'(if3.rd_row) < ROWS) ?
                     board[if3.rd_col][if3.rd_row] : 2'b11;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: address range of every read, and scoreboard pop on each done
    always @(negedge clk) begin
        if (!reset) begin
            if (if4.rd_en) begin
                rd_cnt4++;
                chk("rd4 in range", int'(if4.rd_col < 3'(COLS) && if4.rd_row < 3'(ROWS)), 1);
            end
            if (if4.done) begin
                if (q4.size() == 0) chk("done4 unexpected", 1, 0);
                else chk("sb4 {err,won,dir}", int'({if4.err, if4.won_game, if4.win_dir}),
                         int'(q4.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (if3.rd_en) begin
                rd_cnt3++;
                chk("rd3 in range", int'(if3.rd_col < 3'(COLS) && if3.rd_row < 3'(ROWS)), 1);
            end
            if (if3.done) begin
                if (q3.size() == 0) chk("done3 unexpected", 1, 0);
                else chk("sb3 {err,won,dir}", int'({if3.err, if3.won_game, if3.win_dir}),
                         int'(q3.pop_front()));
            end
        end
    end

    // Reference: a direction wins when 1 + run forward + run backward reaches the win length;
    // the first winning direction in order 0..3 is reported.
    function automatic logic [3:0] model(input int wl, input bit p, input int loc, input int h,
                                         input bit early);
        int dx[4] = '{1, 0, 1, 1};
        int dy[4] = '{0, 1, 1, -1};
        logic [1:0] code;
        int n, c, r, s;
        if (early) return 4'b0100;
        if (loc >= COLS || h >= ROWS) return 4'b1000;
        code = {p, ~p};
        for (int d = 0; d < 4; d++) begin
            n = 1;
            for (int side = 0; side < 2; side++) begin
                s = (side == 0) ? 1 : -1;
                for (int k = 1; k < 16; k++) begin
                    c = loc + s * k * dx[d];
                    r = h + s * k * dy[d];
                    if (c < 0 || c >= COLS || r < 0 || r >= ROWS) break;
                    if (board[c][r] != code) break;
                    n++;
                end
            end
            if (n >= wl) return {2'b01, 2'(d)};
        end
        return 4'b0000;
    endfunction

    task automatic clear_board();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) board[c][r] = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        early_win = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issues one scan; glitch > 0 re-asserts start (as an early-win request) that many
    // cycles in, which the busy scanners must ignore.
    task automatic run_scan(input bit p, input int loc, input int h, input bit early,
                            input int glitch);
        int  n, l4, l3, r4, r3;
        bit  s4, s3, quick;
        quick = early || loc >= COLS || h >= ROWS;
        q4.push_back(model(4, p, loc, h, early));
        q3.push_back(model(3, p, loc, h, early));
        r4 = rd_cnt4;
        r3 = rd_cnt3;
        start = 1'b1; player = p; location = loc[2:0]; height = h[2:0]; early_win = early;
        @(posedge clk);
        #1 start = 1'b0; early_win = 1'b0;
        n = 1; s4 = 0; s3 = 0; l4 = 0; l3 = 0;
        while (!(s4 && s3) && n <= 200) begin
            if (!s4 && if4.done) begin s4 = 1; l4 = n; end
            if (!s3 && if3.done) begin s3 = 1; l3 = n; end
            if (glitch > 0 && n == glitch) begin
                start = 1'b1; early_win = 1'b1; player = ~p;
            end else begin
                start = 1'b0; early_win = 1'b0;
            end
            if (!(s4 && s3)) begin
                @(posedge clk);
                #1 n++;
            end
        end
        start = 1'b0; early_win = 1'b0;
        if (!(s4 && s3)) begin
            chk("done timeout", 0, 1);
            do_reset();
            q4.delete();
            q3.delete();
        end else if (quick) begin
            chk("quick latency4", l4, 1);
            chk("quick latency3", l3, 1);
            chk("quick no rd_en4", rd_cnt4 - r4, 0);
            chk("quick no rd_en3", rd_cnt3 - r3, 0);
        end else begin
            chk("latency4 bound", int'(l4 <= 16 * 3 + 1), 1);
            chk("latency3 bound", int'(l3 <= 16 * 2 + 1), 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v, p, loc, h;
        bit early;
        clear_board();
        do_reset();

        chk("reset busy", if4.busy, 0);
        chk("reset done", if4.done, 0);
        chk("reset won", if4.won_game, 0);
        chk("reset win_dir", if4.win_dir, 0);
        chk("reset err", if4.err, 0);
        chk("reset rd_en", if4.rd_en, 0);
        chk("reset rd_col", if4.rd_col, 0);
        chk("reset rd_row", if4.rd_row, 0);

        // Horizontal win straddling the new piece
        board[1][0] = 2'b10; board[2][0] = 2'b10; board[4][0] = 2'b10;
        run_scan(1, 3, 0, 0, 0);
        chk("horiz won", if4.won_game, 1);
        chk("horiz dir", if4.win_dir, 0);

        // Vertical win on top of a column
        clear_board();
        for (int r = 0; r < 3; r++) board[5][r] = 2'b01;
        run_scan(0, 5, 3, 0, 0);
        chk("vert won", if4.won_game, 1);
        chk("vert dir", if4.win_dir, 1);

        // Rising diagonal, then an isolated corner piece
        clear_board();
        for (int i = 0; i < 3; i++) board[i][i] = 2'b10;
        run_scan(1, 3, 3, 0, 0);
        chk("rising won", if4.won_game, 1);
        chk("rising dir", if4.win_dir, 2);
        clear_board();
        run_scan(1, 6, 0, 0, 0);
        chk("corner won", if4.won_game, 0);

        // Three in a row: wins only for the shorter win length
        board[0][0] = 2'b01; board[1][0] = 2'b01;
        run_scan(0, 2, 0, 0, 0);
        chk("three won4", if4.won_game, 0);
        chk("three err4", if4.err, 0);
        chk("three won3", if3.won_game, 1);

        // Early win and out-of-range origin
        run_scan(0, 2, 1, 1, 0);
        chk("early won", if4.won_game, 1);
        run_scan(1, 7, 0, 0, 0);
        chk("oor err", if4.err, 1);
        chk("oor won", if4.won_game, 0);

        // Start during a scan is ignored
        clear_board();
        run_scan(1, 3, 2, 0, 3);
        chk("glitch won", if4.won_game, 0);

        // Reset mid-scan aborts without done
        start = 1'b1; player = 1'b0; location = 3'd3; height = 3'd2;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort busy", if4.busy, 0);
        chk("abort done", if4.done, 0);
        chk("abort rd_en", if4.rd_en, 0);
        chk("abort rd_row", if4.rd_row, 0);
        chk("abort won", if4.won_game, 0);
        chk("abort err", if4.err, 0);
        repeat (60) @(posedge clk);
        #1;
        board[1][0] = 2'b10; board[2][0] = 2'b10; board[4][0] = 2'b10;
        run_scan(1, 3, 0, 0, 0);
        chk("after abort won", if4.won_game, 1);

        // Randomized boards and moves
        for (int it = 0; it < 300; it++) begin
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++) begin
                    v = $urandom_range(0, 19);
                    board[c][r] = (v < 8) ? 2'b00 : (v < 13) ? 2'b01 : (v < 18) ? 2'b10 : 2'b11;
                end
            p = $urandom_range(0, 1);
            loc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, COLS - 1);
            h = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(0, ROWS - 1);
            early = ($urandom_range(0, 15) == 0);
            run_scan(p[0], loc, h, early, 0);
        end

        repeat (5) @(posedge clk);
        chk("queue4 drained", q4.size(), 0);
        chk("queue3 drained", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
